// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory access unit.
//   size_t  - access size encoding as carried on the Size port
//   state_t - controller states
//   WORD_W  - RAM data word width
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: combinational big-endian lane steering.
//   size        in  2       access size (size_t encoding)
//   is_unsigned in  1       1 = zero-extend loads, 0 = sign-extend
//   wdata       in  WORD_W  right-aligned store data
//   rdata       in  WORD_W  word read from the RAM at the access address
//   load_val    out WORD_W  extracted and extended load result
//   merge_val   out WORD_W  store word with neighbouring bytes preserved
module mem_byte_lane
    import mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] load_val,
    output logic [WORD_W-1:0] merge_val
);

    // The addressed byte is the most significant one of the RAM word.
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_s = rdata[31:24];
    assign half_s = rdata[31:16];

    always_comb begin
        load_val  = rdata;
        merge_val = wdata;
        case (size_t'(size))
            SZ_BYTE: begin
                load_val  = is_unsigned ? {24'h000000, byte_s}
                                        : {{24{byte_s[7]}}, byte_s};
                merge_val = {wdata[7:0], rdata[23:0]};
            end
            SZ_HALF: begin
                load_val  = is_unsigned ? {16'h0000, half_s}
                                        : {{16{half_s[15]}}, half_s};
                merge_val = {wdata[15:0], rdata[15:0]};
            end
            default: begin
                load_val  = rdata;
                merge_val = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller for a byte-addressed big-endian
// 32-bit RAM that writes four bytes on the falling clock edge.
//   CLK, RST   clock (rising edge), synchronous active-high reset
//   Req        request valid, sampled only in IDLE
//   Op_Store   1 = store, 0 = load
//   Size       00 byte, 01 half, 10 word, 11 illegal
//   Unsigned   load extension: 1 = zero, 0 = sign
//   Addr       byte address (most significant byte of the access)
//   WData      right-aligned store data
//   RData      load result, held until the next completed load
//   Ack        one-cycle completion pulse
//   Err        illegal Size, valid with Ack
//   Busy       high in every state except IDLE
//   Mem_Addr, Mem_WData, Mem_EN  to the RAM
//   Mem_RData  combinational read data from the RAM
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int N = 1024,
    parameter int G = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req,
    input  logic              Op_Store,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [G-1:0]      Addr,
    input  logic [WORD_W-1:0] WData,
    output logic [WORD_W-1:0] RData,
    output logic              Ack,
    output logic              Err,
    output logic              Busy,
    output logic [G-1:0]      Mem_Addr,
    output logic [WORD_W-1:0] Mem_WData,
    output logic              Mem_EN,
    input  logic [WORD_W-1:0] Mem_RData
);

    // Addresses wrap modulo the RAM depth (N is a power of two).
    localparam logic [G-1:0] ADDR_MASK = G'(N - 1);

    state_t            state, state_next;
    logic              mem_en_next, ack_next, err_next;
    logic              op_store_q, unsigned_q;
    size_t             size_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] load_val, merge_val;
    logic              accept;

    assign accept = (state == IDLE) && Req;
    assign Busy   = (state != IDLE);

    mem_byte_lane u_lane (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .rdata       (Mem_RData),
        .load_val    (load_val),
        .merge_val   (merge_val)
    );

    always_comb begin
        state_next  = state;
        err_next    = 1'b0;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (size_t'(Size) == SZ_ILL) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else if (Op_Store && size_t'(Size) == SZ_WORD) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = op_store_q ? WR : DONE;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Strobes are registered from the next state so they line up
        // exactly with the WR and DONE cycles.
        mem_en_next = (state_next == WR);
        ack_next    = (state_next == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            Mem_EN     <= 1'b0;
            Ack        <= 1'b0;
            Err        <= 1'b0;
            RData      <= '0;
            Mem_Addr   <= '0;
            Mem_WData  <= '0;
            op_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= SZ_BYTE;
            wdata_q    <= '0;
        end else begin
            state  <= state_next;
            Mem_EN <= mem_en_next;
            Ack    <= ack_next;
            Err    <= err_next;

            if (accept) begin
                op_store_q <= Op_Store;
                unsigned_q <= Unsigned;
                size_q     <= size_t'(Size);
                wdata_q    <= WData;
                Mem_Addr   <= Addr & ADDR_MASK;
                // Word stores skip RD, so the write word is loaded now.
                if (Op_Store && size_t'(Size) == SZ_WORD)
                    Mem_WData <= WData;
            end

            // RD: Mem_RData reflects the latched address; capture it.
            if (state == RD) begin
                if (op_store_q)
                    Mem_WData <= merge_val;
                else
                    RData <= load_val;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator and controller for the team's byte-addressed, big-endian 32-bit RAM port: Addr, Data_In, EN, Data_Out.
- The RAM always writes four bytes (A..A+3) on the falling clock edge when EN is high. Its read data is combinational from the address.
- This block sits between the CPU load/store stage and that RAM. It accepts byte, halfword and word loads and stores through a Req/Ack handshake.
- Sub-word stores use read-modify-write so that neighbouring bytes are preserved. Loads are sign- or zero-extended.

Parameters:
- N, 1024, RAM depth in bytes.
- G, 10, address width. Addresses wrap modulo 2^G; N = 2^G is required.

Ports:
- CLK  in  1  clock. The block updates on the rising edge; the RAM writes on the falling edge.
- RST  in  1  synchronous, active-high reset.
- Req  in  1  request valid. Sampled only in IDLE.
- Op_Store  in  1  1 = store, 0 = load.
- Size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- Unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- Addr  in  G  byte address of the access (most-significant byte).
- WData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- RData  out  32  load result. Valid while Ack = 1 and held until the next accepted load.
- Ack  out  1  one-cycle completion pulse.
- Err  out  1  illegal Size. Valid with Ack.
- Busy  out  1  high in every state except IDLE.
- Mem_Addr  out  G  to RAM Addr.
- Mem_WData  out  32  to RAM Data_In.
- Mem_EN  out  1  to RAM EN.
- Mem_RData  in  32  from RAM Data_Out.

Behaviour:
- Reset: the FSM goes to IDLE. RData = 0, Ack = 0, Err = 0, Busy = 0, Mem_EN = 0, Mem_Addr = 0, Mem_WData = 0. RST does not touch RAM contents.
- States: IDLE, RD, WR, DONE.
- IDLE with Req = 1 latches Op_Store, Size, Unsigned, Addr and WData, then moves to:
  - RD, for a load or a sub-word store;
  - WR, for a word store;
  - DONE with Err set, for Size = 11. No RAM access occurs.
- Req while Busy = 1 is ignored and not queued. Req in the DONE cycle is also ignored.
- RD: Mem_Addr = latched address and Mem_EN = 0. At the next edge Mem_RData is captured.
  - Load: the result is extracted and extended into RData, then the FSM goes to DONE.
  - Store: the merged word is formed, then the FSM goes to WR.
- Load extraction (big-endian):
  - byte = Mem_RData[31:24];
  - half = Mem_RData[31:16];
  - word = Mem_RData.
- Store merge:
  - byte → {WData[7:0], captured[23:0]};
  - half → {WData[15:0], captured[15:0]};
  - word → WData, with no RD state.
- WR: Mem_EN = 1 for exactly one cycle, with Mem_Addr and Mem_WData stable for the whole cycle so the RAM samples them on the falling edge. Next state is DONE.
- DONE: Ack = 1 for one cycle, and Err reflects the request. Next state is IDLE.
- Mem_EN, Ack and Err are registered outputs decoded from the next state. They are never high outside WR and DONE respectively.
- Latency (rising edges from the accepting edge to Ack high):
  - load: 2;
  - word store: 2;
  - sub-word store: 3;
  - illegal: 1.
- Wrap-around: accesses near the top of memory touch A, A+1, A+2, A+3 mod 2^G through the RAM's own wrap. This block does no alignment check, and unaligned addresses are legal.
- RST mid-operation: at the next edge the FSM is in IDLE with Mem_EN = 0, and no Ack is issued for the aborted request. A store aborted in RD leaves memory unchanged.
- RData is held through store completions.

Decomposition:
- Package mem_pkg holds:
  - the size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL);
  - the state_t enum (IDLE, RD, WR, DONE);
  - the constant WORD_W = 32.
- One combinational sub-module, mem_byte_lane. Inputs: size, unsigned flag, WData and the captured read word. Outputs: the extended load value and the merged store word.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- RAM reset to zero. Word store 0xDEADBEEF @0x010, then word load @0x010 → Mem_EN high in exactly one cycle, Ack 2 edges after each accept, RData = 0xDEADBEEF.
- Byte store 0x5A @0x011, then word load @0x010 → the FSM passes through RD; RData = 0xDE5ABEEF.
- Byte loads @0x010 and half load @0x012, signed and unsigned:
  - byte signed → 0xFFFFFFDE;
  - byte unsigned → 0x000000DE;
  - half signed @0x012 → 0xFFFFBEEF.
- Wrap: word store 0x11223344 @0x3FE (G = 10), then word load @0x3FE → 0x11223344; unsigned half load @0x000 → 0x00003344.
- Size = 11 store → Ack and Err high one edge after accept, Mem_EN never high, and a subsequent word load @0x010 is unchanged. Req pulsed while Busy is ignored, giving exactly one Ack.
- Half store issued, then RST asserted in the RD cycle → next cycle IDLE, Mem_EN = 0, Busy = 0, no Ack, and memory at the target is unchanged.
